// File: rtl/irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt controller.
// The CPU-side bus master drives the strobes; irq_ctrl answers with read data.
interface irq_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata,
    input  avs_readdatavalid
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata,
    output avs_readdatavalid
  );
endinterface

// File: rtl/irq_ctrl.sv
// Prioritised, maskable interrupt controller with level/edge sources,
// W1C pending bits and a one-cycle irq_clr pulse back to acked sources.
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] src_irq,
  output logic [N_SRC-1:0] irq_clr,
  output logic             cpu_irq
);

  logic [N_SRC-1:0] src_q, src_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] en_q, en_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] clr_q, clr_d;
  logic             cpu_irq_q, cpu_irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eff;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] ack_oh;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] wdat;
  logic             valid;
  logic [4:0]       id;
  logic             wr_pend, wr_en, wr_mode, wr_ack;
  logic [31:0]      rmux;

  logic unused_wdata;
  assign unused_wdata = ^bus.avs_writedata;

  always_comb begin
    wdat    = bus.avs_writedata[N_SRC-1:0];
    src_d   = src_irq;
    rise    = src_irq & ~src_q;
    eff     = (pend_q & mode_q) | (src_q & ~mode_q);
    act     = eff & en_q;
    valid   = |act;
    id      = '0;
    // Walk downward so the lowest active index is written last.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) id = 5'(i);
    end

    wr_pend = bus.avs_write && (bus.avs_address == 3'd0);
    wr_en   = bus.avs_write && (bus.avs_address == 3'd1);
    wr_mode = bus.avs_write && (bus.avs_address == 3'd2);
    wr_ack  = bus.avs_write && (bus.avs_address == 3'd4);

    ack_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_oh[i] = wr_ack && (bus.avs_writedata[7:0] == 8'(i));
    end

    w1c    = wr_pend ? (wdat & mode_q) : '0;
    en_d   = wr_en   ? wdat : en_q;
    mode_d = wr_mode ? wdat : mode_q;
    // Set wins over clear; leaving edge mode drops the latched bit.
    pend_d = ((pend_q & ~(w1c | ack_oh)) | (rise & mode_q)) & mode_d;

    clr_d     = ack_oh;
    cpu_irq_d = valid;

    rmux = '0;
    unique case (1'b1)
      (bus.avs_address == 3'd0): rmux = 32'(eff);
      (bus.avs_address == 3'd1): rmux = 32'(en_q);
      (bus.avs_address == 3'd2): rmux = 32'(mode_q);
      (bus.avs_address == 3'd3): rmux = {valid, 26'd0, id};
      default:                   rmux = '0;
    endcase

    rdata_d  = bus.avs_read ? rmux : '0;
    rvalid_d = bus.avs_read;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      clr_q     <= '0;
      cpu_irq_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      src_q     <= src_d;
      pend_q    <= pend_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      clr_q     <= clr_d;
      cpu_irq_q <= cpu_irq_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign irq_clr               = clr_q;
  assign cpu_irq               = cpu_irq_q;
  assign bus.avs_readdata      = rdata_q;
  assign bus.avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register table, then level/edge/priority,
// collision, invalid-ack and mid-pulse reset sequences.
module tb_irq_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] src_irq;
  logic [N-1:0] irq_clr;
  logic         cpu_irq;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .src_irq (src_irq),
    .irq_clr (irq_clr),
    .cpu_irq (cpu_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] a,
                    input logic [31:0] exp);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    chk({name, ".rdv"}, 32'(bus.avs_readdatavalid), 32'd1);
    chk(name, bus.avs_readdata, exp);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src_irq = src_irq | m;
    @(negedge clk);
    src_irq = src_irq & ~m;
  endtask

  initial begin
    src_irq               = '0;
    bus.avs_address       = '0;
    bus.avs_read          = 1'b0;
    bus.avs_write         = 1'b0;
    bus.avs_writedata     = '0;

    cyc(2);
    chk("rst.cpu_irq", 32'(cpu_irq), 32'd0);
    chk("rst.irq_clr", 32'(irq_clr), 32'd0);
    chk("rst.rdv", 32'(bus.avs_readdatavalid), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    for (int a = 0; a < 8; a++)
      vt.push_back('{0, 3'(a), 32'd0, 32'd0});
    vt.push_back('{1, 3'd1, 32'hFFFF_FFFF, 32'd0});
    vt.push_back('{0, 3'd1, 32'd0, 32'h0000_00FF});
    vt.push_back('{1, 3'd2, 32'h1234_56A5, 32'd0});
    vt.push_back('{0, 3'd2, 32'd0, 32'h0000_00A5});
    vt.push_back('{0, 3'd0, 32'd0, 32'd0});
    vt.push_back('{0, 3'd3, 32'd0, 32'd0});
    vt.push_back('{1, 3'd5, 32'hFFFF_FFFF, 32'd0});
    vt.push_back('{1, 3'd7, 32'hFFFF_FFFF, 32'd0});
    vt.push_back('{0, 3'd5, 32'd0, 32'd0});
    vt.push_back('{0, 3'd7, 32'd0, 32'd0});
    vt.push_back('{0, 3'd4, 32'd0, 32'd0});
    vt.push_back('{1, 3'd1, 32'd0, 32'd0});
    vt.push_back('{1, 3'd2, 32'd0, 32'd0});
    vt.push_back('{0, 3'd1, 32'd0, 32'd0});
    vt.push_back('{0, 3'd2, 32'd0, 32'd0});

    foreach (vt[i]) begin
      if (vt[i].wr) begin
        wr(vt[i].addr, vt[i].data);
        chk($sformatf("vec%0d.rdv", i), 32'(bus.avs_readdatavalid), 32'd0);
      end else begin
        rd($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
      end
      chk($sformatf("vec%0d.irq", i), 32'(cpu_irq), 32'd0);
      chk($sformatf("vec%0d.clr", i), 32'(irq_clr), 32'd0);
    end

    // Level source 2
    wr(3'd1, 32'h04);
    src_irq[2] = 1'b1;
    cyc(1);
    chk("lvl.t1", 32'(cpu_irq), 32'd0);
    cyc(1);
    chk("lvl.t2", 32'(cpu_irq), 32'd1);
    rd("lvl.active", 3'd3, 32'h8000_0002);
    wr(3'd4, 32'd2);
    chk("lvl.clr", 32'(irq_clr), 32'h04);
    chk("lvl.irq_hold", 32'(cpu_irq), 32'd1);
    cyc(1);
    src_irq[2] = 1'b0;
    chk("lvl.clr_once", 32'(irq_clr), 32'd0);
    cyc(2);
    chk("lvl.irq_fall", 32'(cpu_irq), 32'd0);
    rd("lvl.pending", 3'd0, 32'd0);

    // Edge source 5
    wr(3'd2, 32'h20);
    wr(3'd1, 32'h20);
    pulse(8'h20);
    chk("edg.t1", 32'(cpu_irq), 32'd0);
    cyc(1);
    chk("edg.t2", 32'(cpu_irq), 32'd1);
    cyc(2);
    rd("edg.pending", 3'd0, 32'h20);
    wr(3'd0, 32'h20);
    chk("edg.w1c_clr", 32'(irq_clr), 32'd0);
    cyc(1);
    chk("edg.irq_drop", 32'(cpu_irq), 32'd0);
    chk("edg.w1c_clr2", 32'(irq_clr), 32'd0);
    rd("edg.pending0", 3'd0, 32'd0);

    // Priority between sources 1 and 6
    wr(3'd2, 32'h42);
    wr(3'd1, 32'h42);
    pulse(8'h42);
    cyc(1);
    rd("pri.pending", 3'd0, 32'h42);
    rd("pri.id1", 3'd3, 32'h8000_0001);
    wr(3'd4, 32'd1);
    chk("pri.clr", 32'(irq_clr), 32'h02);
    rd("pri.id6", 3'd3, 32'h8000_0006);
    pulse(8'h02);
    cyc(1);
    rd("pri.id1b", 3'd3, 32'h8000_0001);
    wr(3'd1, 32'h40);
    rd("pri.mask", 3'd3, 32'h8000_0006);
    // Read and write in one cycle returns the pre-write value
    bus.avs_address   = 3'd1;
    bus.avs_writedata = 32'h0;
    bus.avs_write     = 1'b1;
    bus.avs_read      = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
    bus.avs_read      = 1'b0;
    chk("rw.old", bus.avs_readdata, 32'h40);
    rd("rw.new", 3'd1, 32'h0);
    wr(3'd2, 32'h00);
    rd("pri.lvl_clears", 3'd0, 32'd0);

    // Collision: rising edge on source 3 during ACK=3
    wr(3'd2, 32'h08);
    wr(3'd1, 32'h08);
    pulse(8'h08);
    cyc(2);
    chk("col.pre", 32'(cpu_irq), 32'd1);
    src_irq[3] = 1'b1;
    wr(3'd4, 32'd3);
    src_irq[3] = 1'b0;
    chk("col.clr", 32'(irq_clr), 32'h08);
    cyc(1);
    chk("col.clr_once", 32'(irq_clr), 32'd0);
    chk("col.irq", 32'(cpu_irq), 32'd1);
    rd("col.pending", 3'd0, 32'h08);

    // Invalid ACK index
    wr(3'd4, 32'd9);
    chk("inv.clr", 32'(irq_clr), 32'd0);
    cyc(1);
    chk("inv.clr2", 32'(irq_clr), 32'd0);
    chk("inv.irq", 32'(cpu_irq), 32'd1);
    rd("inv.pending", 3'd0, 32'h08);
    rd("inv.enable", 3'd1, 32'h08);
    rd("inv.mode", 3'd2, 32'h08);

    // Reset during an irq_clr pulse
    wr(3'd4, 32'd3);
    chk("rst2.pre_clr", 32'(irq_clr), 32'h08);
    chk("rst2.pre_irq", 32'(cpu_irq), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst2.clr", 32'(irq_clr), 32'd0);
    chk("rst2.irq", 32'(cpu_irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    rd("rst2.enable", 3'd1, 32'd0);
    rd("rst2.mode", 3'd2, 32'd0);
    rd("rst2.pending", 3'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end
endmodule
